tffcase: RTL and testbench

Registered toggle flip-flop with a synchronous clear, used as a single-bit (or bit-vector) toggle storage element in the sequential datapath. Each bit of `q` inverts on the rising clock edge when its `t` bit is high. Each bit holds its value when its `t` bit is low. The whole register is forced to a known value by an active-low synchronous clear. The block is a leaf cell with no handshake. It is intended as the reference toggle primitive for counters and dividers built above it.

---
 rtl/tffcase.sv | 23 ++
 tb/tb_tffcase.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tffcase.sv
// tffcase: registered toggle flip-flop, one independent toggle bit per q bit.
// Ports: clk (rising edge), clr (sync active-low clear to RESET_VAL),
//        t (per-bit toggle enable), q (registered state, straight from flops).
module tffcase #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // Clear wins over toggle; bits never interact, so a plain XOR suffices.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q <= RESET_VAL;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: tb/tb_tffcase.sv
// tb_tffcase: scoreboard bench for tffcase, scalar and 4-bit instances.
// Expected q values come from a reference model and are queued per cycle.
module tb_tffcase;

    typedef struct {
        string      tag;
        logic       q1;
        logic [3:0] q4;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr1 = 1'b1;
    logic       t1 = 1'b0;
    logic       q1;
    logic       clr4 = 1'b1;
    logic [3:0] t4 = 4'b0000;
    logic [3:0] q4;

    logic       m1;
    logic [3:0] m4;
    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;

    always #50 clk = ~clk;

    tffcase u1 (
        .clk(clk),
        .clr(clr1),
        .t  (t1),
        .q  (q1)
    );

    tffcase #(
        .WIDTH    (4),
        .RESET_VAL(4'b1010)
    ) u4 (
        .clk(clk),
        .clr(clr4),
        .t  (t4),
        .q  (q4)
    );

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle on both instances, queue model results, check after edge.
    task automatic cyc(input string tag, input logic c1, input logic tt1,
                       input logic c4, input logic [3:0] tt4);
        exp_t e;
        @(negedge clk);
        clr1 = c1;
        t1   = tt1;
        clr4 = c4;
        t4   = tt4;
        m1 = c1 ? (m1 ^ tt1) : 1'b0;
        m4 = c4 ? (m4 ^ tt4) : 4'b1010;
        e.tag = tag;
        e.q1  = m1;
        e.q4  = m4;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 4'd1, 4'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_q1"}, {3'b000, q1}, {3'b000, e.q1});
            check({e.tag, "_q4"}, q4, e.q4);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        m1 = 1'bx;
        m4 = 4'bxxxx;

        repeat (2) cyc("clear", 1'b0, 1'b0, 1'b0, 4'b0000);
        repeat (3) cyc("clr_beats_t", 1'b0, 1'b1, 1'b0, 4'b1111);

        // Toggle: q1 1,0,1,0 ; q4 1100,1010,...
        repeat (4) cyc("toggle", 1'b1, 1'b1, 1'b1, 4'b0110);

        cyc("to_one", 1'b1, 1'b1, 1'b1, 4'b0001);
        repeat (3) cyc("hold", 1'b1, 1'b0, 1'b1, 4'b0000);

        cyc("mid_clr", 1'b0, 1'b1, 1'b0, 4'b1111);
        cyc("resume", 1'b1, 1'b1, 1'b1, 4'b0101);

        // Clear and toggle pulsed strictly between edges must not move q.
        @(negedge clk);
        clr1 = 1'b0;
        clr4 = 1'b0;
        t1   = 1'b1;
        t4   = 4'b1111;
        #10;
        check("between_q1", {3'b000, q1}, {3'b000, m1});
        check("between_q4", q4, m4);
        clr1 = 1'b1;
        clr4 = 1'b1;
        t1   = 1'b0;
        t4   = 4'b0000;
        #10;
        check("between2_q1", {3'b000, q1}, {3'b000, m1});
        check("between2_q4", q4, m4);
        cyc("after_between", 1'b1, 1'b0, 1'b1, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            cyc("rand", ($urandom_range(0, 7) != 0), 1'($urandom),
                ($urandom_range(0, 7) != 0), 4'($urandom));
        end

        if (sb.size() != 0) begin
            check("sb_drain", 4'(sb.size()), 4'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
